// File: rtl/ysyx_201979054_mem_req_arbiter.sv
// Shared AXI memory-port arbiter: picks one of NUM_REQ cache/MMIO requesters,
// launches its read or write, counts read beats and pulses completion back.
module ysyx_201979054_mem_req_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int BURST_LEN = 16,
   parameter int RR_MODE   = 0,
   localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
   input  logic               clk,
   input  logic               arst,
   input  logic [NUM_REQ-1:0] i_rd_req,
   input  logic [NUM_REQ-1:0] i_wr_req,
   input  logic [NUM_REQ-1:0] i_single,
   input  logic               i_r_valid,
   input  logic               i_r_last,
   input  logic               i_b_resp,
   output logic               o_start_read_axi,
   output logic               o_start_write_axi,
   output logic [CNT_W-1:0]   o_rd_burst_len,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [NUM_REQ-1:0] o_done,
   output logic               o_busy,
   output logic               o_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, LAUNCH, RD_WAIT, WR_WAIT} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic               is_wr_q, is_wr_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] req;
   logic               found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand_idx;
   int unsigned        cand;
   logic [CNT_W:0]     cnt_inc;
   logic               start_rd, start_wr, done_fire;
   logic [IDX_W-1:0]   rr_next;

   // Winner search: fixed scans from index 0, round-robin from the RR pointer.
   always_comb begin
      req      = i_rd_req | i_wr_req;
      found    = 1'b0;
      win_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (RR_MODE != 0) cand = (32'(rr_q) + k) % NUM_REQ;
         else              cand = k;
         cand_idx = IDX_W'(cand);
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign rr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      idx_d     = idx_q;
      rr_d      = rr_q;
      is_wr_d   = is_wr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      done_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               idx_d            = win_idx;
               is_wr_d          = i_wr_req[win_idx];
               // Burst length is captured with the grant so it is valid alongside the start pulse.
               len_d            = i_single[win_idx] ? ONE_C : BURST_C;
               state_d          = LAUNCH;
            end
         end
         LAUNCH: begin
            cnt_d = '0;
            if (is_wr_q) begin
               start_wr = 1'b1;
               state_d  = WR_WAIT;
            end else begin
               start_rd = 1'b1;
               state_d  = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (i_r_valid) begin
               cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_inc[CNT_W-1:0];
               if (i_r_last) begin
                  done_fire = 1'b1;
                  if (cnt_inc != {1'b0, len_q}) err_d = 1'b1;
                  grant_d = '0;
                  rr_d    = rr_next;
                  state_d = IDLE;
               end
            end
         end
         WR_WAIT: begin
            if (i_b_resp) begin
               done_fire = 1'b1;
               grant_d   = '0;
               rr_d      = rr_next;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         rr_q    <= '0;
         is_wr_q <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         is_wr_q <= is_wr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign o_start_read_axi  = start_rd;
   assign o_start_write_axi = start_wr;
   assign o_rd_burst_len    = len_q;
   assign o_grant           = grant_q;
   assign o_done            = done_fire ? grant_q : '0;
   assign o_busy            = (state_q != IDLE);
   assign o_err             = err_q;

endmodule

// File: tb/tb_ysyx_201979054_mem_req_arbiter.sv
// Directed bench: a fixed-priority 2-requester instance and a round-robin 3-requester instance.
module tb_ysyx_201979054_mem_req_arbiter;

   logic       clk = 1'b0;
   logic       arst = 1'b0;

   logic [1:0] rd, wr, sg;
   logic       rv, rl, br;
   logic       srd, swr, busy, err;
   logic [4:0] len;
   logic [1:0] g, d;

   logic [2:0] rd3, wr3, sg3;
   logic       rv3, rl3, br3;
   logic       srd3, swr3, busy3, err3;
   logic [4:0] len3;
   logic [2:0] g3, d3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_201979054_mem_req_arbiter #(.NUM_REQ(2), .BURST_LEN(16), .RR_MODE(0)) u0 (
      .clk(clk), .arst(arst), .i_rd_req(rd), .i_wr_req(wr), .i_single(sg),
      .i_r_valid(rv), .i_r_last(rl), .i_b_resp(br),
      .o_start_read_axi(srd), .o_start_write_axi(swr), .o_rd_burst_len(len),
      .o_grant(g), .o_done(d), .o_busy(busy), .o_err(err));

   ysyx_201979054_mem_req_arbiter #(.NUM_REQ(3), .BURST_LEN(16), .RR_MODE(1)) u1 (
      .clk(clk), .arst(arst), .i_rd_req(rd3), .i_wr_req(wr3), .i_single(sg3),
      .i_r_valid(rv3), .i_r_last(rl3), .i_b_resp(br3),
      .o_start_read_axi(srd3), .o_start_write_axi(swr3), .o_rd_burst_len(len3),
      .o_grant(g3), .o_done(d3), .o_busy(busy3), .o_err(err3));

   typedef struct {
      logic [1:0] rd, wr, sg;
      logic       rv, rl, br;
      logic [1:0] g;
      logic       srd, swr;
      logic [1:0] d;
      logic       busy, err;
      logic [4:0] len;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(input logic [1:0] rd_i, wr_i, sg_i, input logic rv_i, rl_i, br_i,
                               input logic [1:0] g_i, input logic srd_i, swr_i,
                               input logic [1:0] d_i, input logic busy_i, err_i,
                               input logic [4:0] len_i);
      vec_t v;
      v.rd = rd_i; v.wr = wr_i; v.sg = sg_i; v.rv = rv_i; v.rl = rl_i; v.br = br_i;
      v.g = g_i; v.srd = srd_i; v.swr = swr_i; v.d = d_i; v.busy = busy_i; v.err = err_i;
      v.len = len_i;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] eg, input logic esrd, eswr,
                          input logic [1:0] ed, input logic ebusy, eerr, input logic [4:0] elen);
      chk({tag, ".grant"}, 32'(g), 32'(eg));
      chk({tag, ".srd"}, 32'(srd), 32'(esrd));
      chk({tag, ".swr"}, 32'(swr), 32'(eswr));
      chk({tag, ".done"}, 32'(d), 32'(ed));
      chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
      chk({tag, ".err"}, 32'(err), 32'(eerr));
      chk({tag, ".len"}, 32'(len), 32'(elen));
   endtask

   task automatic drv(input logic [1:0] rd_i, wr_i, sg_i, input logic rv_i, rl_i, br_i);
      rd = rd_i; wr = wr_i; sg = sg_i; rv = rv_i; rl = rl_i; br = br_i;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] rr_exp [4];
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

      //      rd     wr     sg     rv    rl    br  | g      srd   swr   d      busy  err   len
      tbl[0] = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
      tbl[1] = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd1);
      tbl[2] = mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd1);
      tbl[3] = mk(2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 5'd1);
      tbl[4] = mk(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1);
      tbl[5] = mk(2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 5'd16);
      tbl[6] = mk(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 5'd16);
      tbl[7] = mk(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 5'd16);
      tbl[8] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd16);
      tbl[9] = mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd16);

      drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      rd3 = '0; wr3 = '0; sg3 = '0; rv3 = 1'b0; rl3 = 1'b0; br3 = 1'b0;

      samp();
      chk_all("reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
      chk("reset.u1_grant", 32'(g3), 32'd0);
      chk("reset.u1_busy", 32'(busy3), 32'd0);
      step();
      arst = 1'b1;

      // Single-beat read, write-before-read ordering, stray responses ignored.
      for (int i = 0; i < 10; i++) begin
         drv(tbl[i].rd, tbl[i].wr, tbl[i].sg, tbl[i].rv, tbl[i].rl, tbl[i].br);
         samp();
         chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].srd, tbl[i].swr, tbl[i].d,
                 tbl[i].busy, tbl[i].err, tbl[i].len);
         step();
      end

      // Finish the 16-beat refill launched by the last vector.
      for (int b = 1; b <= 16; b++) begin
         drv(2'b01, 2'b00, 2'b00, 1'b1, (b == 16), 1'b0);
         samp();
         chk($sformatf("refill.b%0d.done", b), 32'(d), (b == 16) ? 32'd1 : 32'd0);
         step();
      end
      drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      samp();
      chk("refill.err", 32'(err), 32'd0);
      chk("refill.idle_busy", 32'(busy), 32'd0);
      step();

      // Both requesters together under fixed priority: 0 wins, then 1.
      drv(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      samp();
      chk("t1.idle_grant", 32'(g), 32'd0);
      step();
      samp();
      chk_all("t1.launch0", 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd16);
      step();
      for (int b = 1; b <= 16; b++) begin
         drv(2'b11, 2'b00, 2'b00, 1'b1, (b == 16), 1'b0);
         samp();
         chk($sformatf("t1.b%0d.done", b), 32'(d), (b == 16) ? 32'd1 : 32'd0);
         step();
      end
      drv(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      samp();
      chk_all("t1.turnaround", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd16);
      step();
      samp();
      chk_all("t1.launch1", 2'b10, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd16);
      step();

      // Short burst: r_last on beat 15 of 16 sets the sticky error.
      for (int b = 1; b <= 15; b++) begin
         drv(2'b10, 2'b00, 2'b00, 1'b1, (b == 15), 1'b0);
         samp();
         chk($sformatf("t4.b%0d.done", b), 32'(d), (b == 15) ? 32'd2 : 32'd0);
         step();
      end
      drv(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      samp();
      chk("t4.err_set", 32'(err), 32'd1);
      step();
      step();
      step();
      samp();
      chk("t4.err_sticky", 32'(err), 32'd1);
      step();

      // Round-robin over three held single-beat requesters.
      rd3 = 3'b111; sg3 = 3'b111;
      for (int k = 0; k < 4; k++) begin
         samp();
         chk($sformatf("t2.%0d.idle_grant", k), 32'(g3), 32'd0);
         step();
         samp();
         chk($sformatf("t2.%0d.grant", k), 32'(g3), 32'(rr_exp[k]));
         chk($sformatf("t2.%0d.srd", k), 32'(srd3), 32'd1);
         chk($sformatf("t2.%0d.swr", k), 32'(swr3), 32'd0);
         step();
         rv3 = 1'b1; rl3 = 1'b1;
         samp();
         chk($sformatf("t2.%0d.done", k), 32'(d3), 32'(rr_exp[k]));
         chk($sformatf("t2.%0d.srd_once", k), 32'(srd3), 32'd0);
         step();
         rv3 = 1'b0; rl3 = 1'b0;
      end
      chk("t2.err", 32'(err3), 32'd0);
      rd3 = '0;

      // Reset in the middle of a burst aborts without a done pulse.
      drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      samp();
      chk("t5.idle_grant", 32'(g), 32'd0);
      step();
      samp();
      chk("t5.launch_srd", 32'(srd), 32'd1);
      step();
      for (int b = 1; b <= 7; b++) begin
         drv(2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
         samp();
         chk($sformatf("t5.b%0d.done", b), 32'(d), 32'd0);
         step();
      end
      drv(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      arst = 1'b0;
      samp();
      chk_all("t5.in_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
      step();
      arst = 1'b1;
      samp();
      chk_all("t5.released", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
      step();
      samp();
      chk_all("t5.regrant", 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 5'd16);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
